// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency fetch-side
// prediction, EX-side mispredict redirect, table training and branch statistics.
module branch_predict_ctrl #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned IDX_W    = 4,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BrValidE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        RedirectE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       cnt;
  } btb_entry_t;

  btb_entry_t  tbl_q [ENTRIES];
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  btb_entry_t       f_ent, e_ent, upd_ent;
  logic             f_hit, e_hit, fire, miss, upd_en;
  logic             unused_pcf_c;

  assign f_idx        = PCF[IDX_W+1:2];
  assign f_tag        = PCF[31:IDX_W+2];
  assign e_idx        = PCE[IDX_W+1:2];
  assign e_tag        = PCE[31:IDX_W+2];
  assign unused_pcf_c = ^PCF[1:0];

  // Fetch-side lookup reads the registered table, so a same-cycle update is not seen
  always_comb begin
    f_ent       = tbl_q[f_idx];
    f_hit       = f_ent.valid && (f_ent.tag == f_tag);
    PredTakenF  = f_hit && f_ent.cnt[1];
    PredTargetF = f_hit ? f_ent.target : 32'd0;
  end

  // EX-side resolve: mispredict on direction, or on target of a predicted-taken branch
  always_comb begin
    fire        = BrValidE && !StallE;
    miss        = fire && ((BranchE != PredTakenE) ||
                           (BranchE && PredTakenE && (PredTargetE != BrTargetE)));
    RedirectE   = miss;
    RedirectPCE = 32'd0;
    if (miss) begin
      RedirectPCE = BranchE ? BrTargetE : 32'(PCE + 32'd4);
    end
  end

  // Training entry and counter next-state
  always_comb begin
    e_ent        = tbl_q[e_idx];
    e_hit        = e_ent.valid && (e_ent.tag == e_tag);
    upd_ent      = e_ent;
    upd_en       = 1'b0;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (fire) begin
      branch_cnt_d = 32'(branch_cnt_q + 32'd1);
      if (miss) begin
        miss_cnt_d = 32'(miss_cnt_q + 32'd1);
      end
      if (e_hit) begin
        upd_en = 1'b1;
        if (BranchE) begin
          upd_ent.target = BrTargetE;
          if (e_ent.cnt != 2'b11) begin
            upd_ent.cnt = 2'(e_ent.cnt + 2'd1);
          end
        end else if (e_ent.cnt != 2'b00) begin
          upd_ent.cnt = 2'(e_ent.cnt - 2'd1);
        end
      end else if (BranchE) begin
        upd_en         = 1'b1;
        upd_ent.valid  = 1'b1;
        upd_ent.tag    = e_tag;
        upd_ent.target = BrTargetE;
        upd_ent.cnt    = CNT_INIT;
      end
    end
  end

  // Reset wins over a simultaneous training update
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, cnt: 2'b01};
      end
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      if (upd_en) begin
        tbl_q[e_idx] <= upd_ent;
      end
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (ENTRIES=16).
module tb_branch_predict_ctrl;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BrValidE, StallE, BranchE, PredTakenE;
  logic [31:0] PCE, BrTargetE, PredTargetE;
  logic        RedirectE;
  logic [31:0] RedirectPCE, BranchCnt, MissCnt;

  int total = 0;
  int bad   = 0;

  branch_predict_ctrl #(.ENTRIES(16), .IDX_W(4), .CNT_INIT(2'b10)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BrValidE(BrValidE), .StallE(StallE), .PCE(PCE), .BranchE(BranchE),
    .BrTargetE(BrTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [31:0] pce, input logic br,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    BrValidE = v; StallE = st; PCE = pce; BranchE = br;
    BrTargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    PCF = pc;
    #1;
    chk({tag, "_taken"}, 32'(PredTakenF), 32'(tk));
    chk({tag, "_target"}, PredTargetF, tg);
  endtask

  task automatic cnts(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, "_brcnt"}, BranchCnt, b);
    chk({tag, "_misscnt"}, MissCnt, m);
  endtask

  task automatic redir(input string tag, input logic r, input logic [31:0] pc);
    chk({tag, "_redirect"}, 32'(RedirectE), 32'(r));
    chk({tag, "_redirpc"}, RedirectPCE, pc);
  endtask

  initial begin
    CPU_RST = 1'b1; PCF = 32'h40;
    idle();
    tick(); tick();
    CPU_RST = 1'b0;

    // reset state
    look("rst", 32'h40, 1'b0, 32'h0);
    cnts("rst", 32'd0, 32'd0);
    redir("rst_idle", 1'b0, 32'h0);

    // cold taken branch allocates weakly-taken entry
    drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    redir("cold", 1'b1, 32'h100);
    tick(); idle();
    look("cold_after", 32'h40, 1'b1, 32'h100);
    cnts("cold_after", 32'd1, 32'd1);

    // three correctly predicted taken resolves saturate the counter
    drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    redir("hit_ok", 1'b0, 32'h0);
    tick(); tick(); tick(); idle();
    cnts("sat", 32'd4, 32'd1);

    // first not-taken: 3->2, still predicts taken
    drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    redir("nt1", 1'b1, 32'h44);
    tick(); idle();
    look("nt1_after", 32'h40, 1'b1, 32'h100);
    cnts("nt1_after", 32'd5, 32'd2);

    // second not-taken: 2->1, now predicts not taken (hit keeps target)
    drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    redir("nt2", 1'b1, 32'h44);
    tick(); idle();
    look("nt2_after", 32'h40, 1'b0, 32'h100);
    cnts("nt2_after", 32'd6, 32'd3);

    // target mismatch on predicted-taken branch
    drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    redir("tgt", 1'b1, 32'h200);
    tick(); idle();
    look("tgt_after", 32'h40, 1'b1, 32'h200);
    cnts("tgt_after", 32'd7, 32'd4);

    // not-taken, predicted not-taken, cold PC: no redirect, no allocation
    drive(1'b1, 1'b0, 32'h200, 1'b0, 32'h600, 1'b0, 32'h0);
    redir("nt_cold", 1'b0, 32'h0);
    tick(); idle();
    look("nt_cold_after", 32'h200, 1'b0, 32'h0);
    cnts("nt_cold_after", 32'd8, 32'd4);

    // stalled mispredicting branch is held, then resolved when stall drops
    drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h200, 1'b1, 32'h200);
    redir("stall", 1'b0, 32'h0);
    tick();
    cnts("stall_after", 32'd8, 32'd4);
    look("stall_after", 32'h40, 1'b1, 32'h200);
    drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h200, 1'b1, 32'h200);
    redir("unstall", 1'b1, 32'h44);
    tick(); idle();
    cnts("unstall_after", 32'd9, 32'd5);
    look("unstall_after", 32'h40, 1'b0, 32'h200);

    // alias: 0x80 shares index 0 with 0x40 and replaces it
    drive(1'b1, 1'b0, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    redir("alias", 1'b1, 32'h300);
    tick(); idle();
    look("alias_new", 32'h80, 1'b1, 32'h300);
    look("alias_old", 32'h40, 1'b0, 32'h0);
    cnts("alias_after", 32'd10, 32'd6);

    // rebuild 0x40 with cnt=1
    drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    tick(); idle();
    look("rebuild", 32'h40, 1'b0, 32'h100);
    cnts("rebuild", 32'd12, 32'd8);

    // read-before-write: same-cycle lookup sees the old counter
    PCF = 32'h40;
    drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("rbw_same_taken", 32'(PredTakenF), 32'd0);
    redir("rbw", 1'b1, 32'h100);
    tick(); idle();
    look("rbw_next", 32'h40, 1'b1, 32'h100);
    cnts("rbw_next", 32'd13, 32'd9);

    // reset beats a simultaneous fire
    CPU_RST = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    CPU_RST = 1'b0;
    idle();
    look("rstfire_40", 32'h40, 1'b0, 32'h0);
    look("rstfire_80", 32'h80, 1'b0, 32'h0);
    cnts("rstfire", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline.
- IF side: looks up a direct-mapped BTB with 2-bit saturating counters and supplies a predicted next PC.
- EX side: takes the branch-decision result and the computed target. On a misprediction it raises a redirect/flush with the correct PC, then trains the table.
- Holds branch and mispredict performance counters.

Parameters:
- ENTRIES, 16, number of BTB entries (power of 2, 4..64).
- IDX_W, 4, log2(ENTRIES); index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2].
- CNT_INIT, 2'b10, counter value written when a new entry is allocated (weakly taken).

Ports:
- CPU_CLK  in  1  core clock, all state updates on rising edge.
- CPU_RST  in  1  synchronous, active-high reset.
- PCF  in  32  fetch PC.
- PredTakenF  out  1  1 = predicted taken for PCF.
- PredTargetF  out  32  predicted target, valid when PredTakenF=1.
- BrValidE  in  1  EX holds a conditional branch (BranchTypeE != NOBRANCH).
- StallE  in  1  EX stage stalled; blocks train/redirect/count.
- PCE  in  32  PC of EX instruction.
- BranchE  in  1  actual outcome from branch decision logic.
- BrTargetE  in  32  computed branch target.
- PredTakenE  in  1  PredTakenF carried down the pipeline to EX.
- PredTargetE  in  32  PredTargetF carried down the pipeline to EX.
- RedirectE  out  1  mispredict; flush IF/ID and load RedirectPCE.
- RedirectPCE  out  32  corrected PC.
- BranchCnt  out  32  resolved branches since reset.
- MissCnt  out  32  mispredicted branches since reset.

Behaviour:
- Table per entry: valid(1), tag(32-IDX_W-2), target(32), cnt(2).
- Reset (CPU_RST=1 at edge):
  - all valid=0, all cnt=2'b01;
  - BranchCnt=0, MissCnt=0;
  - combinational outputs resolve to 0 while the table is empty.
- Lookup is combinational from registered table state, zero latency:
  - hit = valid && tag match;
  - PredTakenF = hit && cnt[1];
  - PredTargetF = hit ? target : 0.
- Resolve is combinational; fire = BrValidE && !StallE.
  - miss = fire && (BranchE != PredTakenE || (BranchE && PredTakenE && PredTargetE != BrTargetE)).
  - RedirectE = miss.
  - RedirectPCE = BranchE ? BrTargetE : PCE+4 (mod 2^32); it is 0 when RedirectE=0.
- Training, on the rising edge when fire=1 and CPU_RST=0, for the entry indexed by PCE:
  - Entry hit, taken: cnt = min(cnt+1, 3); target = BrTargetE.
  - Entry hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - No hit, taken: allocate/replace. valid=1, tag, target=BrTargetE, cnt=CNT_INIT.
  - No hit, not taken: table unchanged (no allocation).
  - In all cases BranchCnt += 1, and MissCnt += 1 if miss. Both wrap at 2^32.
- Same-index lookup and update in one cycle: the lookup returns the pre-update value (read-before-write). No bypass.
- StallE=1: no redirect, no training, no count, even if BrValidE=1. The branch is resolved on the cycle StallE drops.
- BrValidE=0: RedirectE=0, table and counters hold.
- Reset has priority over a simultaneous fire: the table is cleared and the update is dropped.
- Flush handling of younger stages is owned by the hazard unit; this block only asserts RedirectE.

Test Plan:
- Reset then lookup:
  - stimulus: CPU_RST 1 cycle, PCF=0x0000_0040;
  - required: PredTakenF=0, PredTargetF=0, BranchCnt=MissCnt=0.
- Cold taken branch:
  - stimulus: fire with PCE=0x40, BranchE=1, BrTargetE=0x100, PredTakenE=0;
  - required: RedirectE=1, RedirectPCE=0x100. Next cycle PCF=0x40 gives PredTakenF=1, PredTargetF=0x100, BranchCnt=1, MissCnt=1.
- Saturation and hysteresis:
  - stimulus: 3 more taken resolves at 0x40 (cnt -> 3), then 1 not-taken with PredTakenE=1;
  - required: the not-taken gives RedirectE=1, RedirectPCE=0x44, cnt=2, PredTakenF still 1.
  - stimulus: a second not-taken;
  - required: cnt=1, PredTakenF=0.
- Target mismatch:
  - stimulus: entry at 0x40 with target 0x100; resolve taken with BrTargetE=0x200, PredTakenE=1, PredTargetE=0x100;
  - required: RedirectE=1, RedirectPCE=0x200, entry target becomes 0x200.
- Stall and alias:
  - stimulus A: BrValidE=1, StallE=1, mispredicting inputs;
  - required A: RedirectE=0, counters unchanged.
  - stimulus B: with 0x40 valid, taken branch at PCE=0x80 (same index for ENTRIES=16);
  - required B: entry replaced with the 0x80 tag, and lookup of 0x40 then misses.
- Simultaneous read/write and reset priority:
  - stimulus: PCF=PCE=0x40 on the cycle training flips cnt 1->2;
  - required: PredTakenF=0 that cycle, 1 the next cycle.
  - stimulus: CPU_RST=1 together with fire;
  - required: table cleared, BranchCnt=0.
